bitop_unit: RTL and testbench
=============================

# bitop_unit

Parametrised, registered bitwise logic unit that generalises the team's fixed 8-bit OR gate (`org8`) to any width and eight operations. It adds a valid/ready handshake on both sides and a burst-accumulate mode that folds a sequence of operand pairs into one result. It sits between operand producers and the datapath result bus. Bare gates cannot take backpressure or do multi-beat reductions; this block can.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat is valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `x`  in  `WIDTH`  operand A.
- `y`  in  `WIDTH`  operand B.
- `op`  in  3  operation select (see Operation).
- `acc_en`  in  1  beat belongs to an accumulate burst.
- `in_last`  in  1  final beat of an accumulate burst; ignored when `acc_en`=0.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  `WIDTH`  result.
- `out_zero`  out  1  `out` is all zeros.
- `out_acc`  out  1  result came from an accumulate burst.

## Operation
- A beat is accepted when `in_valid && in_ready`. A result transfers when `out_valid && out_ready`.
- Operation select, f(x,y):
  - 0 AND; 1 OR; 2 XOR; 3 NAND; 4 NOR; 5 XNOR.
  - 6 ANDN, i.e. x & ~y.
  - 7 ORN, i.e. x | ~y.
- Single mode (`acc_en`=0): each accepted beat produces one result, f(x,y).
- Accumulate mode (`acc_en`=1) has two states.
- State IDLE:
  - An accepted beat with `acc_en`=1 and `in_last`=0 loads `acc` = f(x,y), latches `op` into `acc_op`, and moves to ACCUM. No result is produced.
  - An accepted beat with `acc_en`=1 and `in_last`=1 is a one-beat burst. It produces f(x,y) with `out_acc`=1 and stays in IDLE.
- State ACCUM:
  - Each accepted beat sets `acc` = `acc` ∘ f_acc_op(x,y).
  - `acc_op` applies to every beat; the `op` and `acc_en` inputs are ignored until the burst ends.
  - ∘ is AND for `acc_op` ∈ {0,3,6}, OR for {1,4,7}, XOR for {2,5}.
  - A beat with `in_last`=1 writes the combined value to the output register with `out_acc`=1 and returns to IDLE.
- `out_zero` = (`out` == 0), registered alongside `out`.
- All arithmetic is exactly `WIDTH` bits. There is no carry and no sign.

## Timing
- Reset values:
  - `out_valid`=0, `out`=0, `out_zero`=1, `out_acc`=0, `in_ready`=1.
  - State=IDLE, `acc`=0, `acc_op`=0.
- Latency: a result is valid on the cycle after the accepting edge, so 1 cycle for single mode and for the last beat of a burst.
- `in_ready` = !`out_valid` || `out_ready` (combinational). There is no bubble under continuous flow: one beat per cycle in single mode.
- Non-last accumulate beats write no output. They are still gated by `in_ready`, which keeps one rule for all beats.
- Simultaneous output transfer and new acceptance in the same cycle: the register reloads and `out_valid` stays 1.
- Output transfer with no acceptance: `out_valid` drops to 0.
- `out`, `out_zero` and `out_acc` stay stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-burst: asynchronous clear of all state. The partial burst is discarded and no result is emitted.
- `WIDTH`=1 is legal: the same behaviour on 1-bit operands.

## Structure
- Package `bitop_pkg` holds:
  - the `op` encoding constants (`OP_AND` … `OP_ORN`);
  - the state encoding (`ST_IDLE`, `ST_ACCUM`);
  - function `bitop_f(op,x,y)`;
  - function `bitop_combine(op,a,b)`.
- One sub-module, `bitop_core`: combinational f(x,y) with a `WIDTH` parameter, instantiated once for incoming beats.
- Top level: FSM, `acc` register, output register, handshake.

## Test plan
- Reset: assert `rst_n`=0 mid-run → all outputs equal their reset values immediately. After release, `in_ready`=1.
- All ops at `WIDTH`=8 with x=8'hCA, y=8'h5C → out is, for ops 0–7:
  - 0 AND: 48
  - 1 OR: DE
  - 2 XOR: 96
  - 3 NAND: B7
  - 4 NOR: 21
  - 5 XNOR: 69
  - 6 ANDN: 82
  - 7 ORN: EB
- Each result arrives 1 cycle after acceptance with `out_acc`=0.
- Sweep x=y=0..255 with `op`=OR → `out`=x on every beat. `out_zero`=1 only for x=0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and `out` holds steady.
  - Release → beats drain in order with no loss or duplication.
- Accumulate with `op`=XOR, beats (01,02), (04,08), last (10,20) → a single result `out`=8'h3F with `out_acc`=1. No output on the first two beats.
- Accumulate with `op`=AND, beats (FF,F0), last (3C,FF) → `out`=8'h30.
- Repeat with `rst_n` pulsed after the first beat → no result. The next single-mode beat behaves normally.

Source files
------------

// File: rtl/bitop_pkg.sv
// Shared encodings and per-bit helper functions for the bitwise logic unit.
// Functions work on single bits so they serve any operand width.
package bitop_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;
  localparam logic [2:0] OP_ORN  = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  function automatic logic bitop_f(input logic [2:0] op, input logic x, input logic y);
    case (op)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NAND: return ~(x & y);
      OP_NOR:  return ~(x | y);
      OP_XNOR: return ~(x ^ y);
      OP_ANDN: return x & ~y;
      OP_ORN:  return x | ~y;
      default: return 1'b0;
    endcase
  endfunction

  // Burst fold operator: the "family" of the burst op decides AND, OR or XOR.
  function automatic logic bitop_combine(input logic [2:0] op, input logic a, input logic b);
    case (op)
      OP_AND, OP_NAND, OP_ANDN: return a & b;
      OP_OR,  OP_NOR,  OP_ORN:  return a | b;
      default:                  return a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/bitop_core.sv
// Combinational WIDTH-bit evaluation of f(x,y) for the selected operation.
module bitop_core
  import bitop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] f_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign f_o[i] = bitop_f(op_i, x_i[i], y_i[i]);
  end

endmodule

// File: rtl/bitop_unit.sv
// Registered bitwise logic unit with valid/ready on both sides and a
// burst-accumulate mode that folds several operand pairs into one result.
module bitop_unit
  import bitop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_acc
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       acc_op_q, acc_op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_zero_q, out_zero_d;
  logic             out_acc_q, out_acc_d;

  logic [2:0]       core_op;
  logic [WIDTH-1:0] f_w;
  logic [WIDTH-1:0] comb_w;
  logic [WIDTH-1:0] load_val;
  logic             accept;
  logic             load;
  logic             load_acc;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Inside a burst the latched op drives the core, not the live op input.
  assign core_op = (state_q == ST_ACCUM) ? acc_op_q : op;

  bitop_core #(.WIDTH(WIDTH)) u_core (
    .op_i (core_op),
    .x_i  (x),
    .y_i  (y),
    .f_o  (f_w)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    acc_op_d = acc_op_q;
    load     = 1'b0;
    load_acc = 1'b0;
    load_val = f_w;
    for (int i = 0; i < WIDTH; i++) begin
      comb_w[i] = bitop_combine(acc_op_q, acc_q[i], f_w[i]);
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!acc_en) begin
            load = 1'b1;
          end else if (in_last) begin
            load     = 1'b1;
            load_acc = 1'b1;
          end else begin
            acc_d    = f_w;
            acc_op_d = op;
            state_d  = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (in_last) begin
            load     = 1'b1;
            load_acc = 1'b1;
            load_val = comb_w;
            state_d  = ST_IDLE;
          end else begin
            acc_d = comb_w;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_d       = out_q;
    out_zero_d  = out_zero_q;
    out_acc_d   = out_acc_q;
    out_valid_d = out_valid_q && !out_ready;
    if (load) begin
      out_d       = load_val;
      out_zero_d  = (load_val == '0);
      out_acc_d   = load_acc;
      out_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      acc_op_q    <= OP_AND;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b1;
      out_acc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      acc_op_q    <= acc_op_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_zero_q  <= out_zero_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_zero  = out_zero_q;
  assign out_acc   = out_acc_q;

endmodule

// File: tb/tb_bitop_unit.sv
// Directed bench for bitop_unit: op table, flow sweep, backpressure,
// accumulate bursts and reset in the middle of a burst.
module tb_bitop_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [2:0]   op;
  logic         acc_en;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_w;
  logic         out_zero;
  logic         out_acc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[10];

  bitop_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .acc_en    (acc_en),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .out_zero  (out_zero),
    .out_acc   (out_acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ae, input logic last);
    in_valid = v;
    op       = o;
    x        = a;
    y        = b;
    acc_en   = ae;
    in_last  = last;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out"},       {24'd0, out_w},     32'd0);
    check({tag, "_out_zero"},  {31'd0, out_zero},  32'd1);
    check({tag, "_out_acc"},   {31'd0, out_acc},   32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    vecs[0] = '{3'd0, 8'hCA, 8'h5C, 8'h48, 1'b0};
    vecs[1] = '{3'd1, 8'hCA, 8'h5C, 8'hDE, 1'b0};
    vecs[2] = '{3'd2, 8'hCA, 8'h5C, 8'h96, 1'b0};
    vecs[3] = '{3'd3, 8'hCA, 8'h5C, 8'hB7, 1'b0};
    vecs[4] = '{3'd4, 8'hCA, 8'h5C, 8'h21, 1'b0};
    vecs[5] = '{3'd5, 8'hCA, 8'h5C, 8'h69, 1'b0};
    vecs[6] = '{3'd6, 8'hCA, 8'h5C, 8'h82, 1'b0};
    vecs[7] = '{3'd7, 8'hCA, 8'h5C, 8'hEB, 1'b0};
    vecs[8] = '{3'd0, 8'h0F, 8'hF0, 8'h00, 1'b1};
    vecs[9] = '{3'd5, 8'hFF, 8'h00, 8'h00, 1'b1};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    check_reset_values("por");
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Op table, back-to-back single beats.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, 1'b0);
      step();
      check($sformatf("op%0d_v%0d_valid", vecs[i].op, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("op%0d_v%0d_out", vecs[i].op, i), {24'd0, out_w}, {24'd0, vecs[i].exp});
      check($sformatf("op%0d_v%0d_zero", vecs[i].op, i), {31'd0, out_zero}, {31'd0, vecs[i].exp_zero});
      check($sformatf("op%0d_v%0d_acc", vecs[i].op, i), {31'd0, out_acc}, 32'd0);
    end

    // Continuous OR sweep: one result per cycle, no bubble.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3'd1, i[7:0], i[7:0], 1'b0, 1'b0);
      check($sformatf("sweep_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      step();
      check($sformatf("sweep_out_%0d", i), {24'd0, out_w}, i);
      check($sformatf("sweep_zero_%0d", i), {31'd0, out_zero}, (i == 0) ? 32'd1 : 32'd0);
    end

    // Drain, then backpressure.
    drive(1'b0, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 8'hA1, 8'hA1, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'd1, 8'hA2, 8'hA2, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_in_ready_%0d", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_valid_%0d", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_hold_%0d", c), {24'd0, out_w}, 32'hA1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_drain_a2", {24'd0, out_w}, 32'hA2);
    drive(1'b1, 3'd1, 8'hA3, 8'hA3, 1'b0, 1'b0);
    step();
    check("bp_drain_a3", {24'd0, out_w}, 32'hA3);
    drive(1'b0, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("bp_drain_empty", {31'd0, out_valid}, 32'd0);

    // XOR burst; op changed mid-burst must be ignored.
    drive(1'b1, 3'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    step();
    check("xor_b1_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 3'd0, 8'h04, 8'h08, 1'b1, 1'b0);
    step();
    check("xor_b2_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 3'd0, 8'h10, 8'h20, 1'b1, 1'b1);
    step();
    check("xor_last_valid", {31'd0, out_valid}, 32'd1);
    check("xor_last_out", {24'd0, out_w}, 32'h3F);
    check("xor_last_acc", {31'd0, out_acc}, 32'd1);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    check("xor_after_valid", {31'd0, out_valid}, 32'd0);

    // AND burst.
    drive(1'b1, 3'd0, 8'hFF, 8'hF0, 1'b1, 1'b0);
    step();
    check("and_b1_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 3'd0, 8'h3C, 8'hFF, 1'b1, 1'b1);
    step();
    check("and_last_out", {24'd0, out_w}, 32'h30);
    check("and_last_acc", {31'd0, out_acc}, 32'd1);
    check("and_last_zero", {31'd0, out_zero}, 32'd0);

    // One-beat burst.
    drive(1'b1, 3'd2, 8'hCA, 8'h5C, 1'b1, 1'b1);
    step();
    check("one_beat_out", {24'd0, out_w}, 32'h96);
    check("one_beat_acc", {31'd0, out_acc}, 32'd1);

    // Reset in the middle of a burst while out holds nonzero data.
    drive(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b0, 1'b0);
    step();
    check("pre_rst_out", {24'd0, out_w}, 32'hFF);
    drive(1'b1, 3'd0, 8'hFF, 8'hF0, 1'b1, 1'b0);
    step();
    check("pre_rst_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_burst");
    #3;
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_novalid", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 3'd1, 8'h12, 8'h34, 1'b0, 1'b0);
    step();
    check("post_rst_single_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_single_out", {24'd0, out_w}, 32'h36);
    check("post_rst_single_acc", {31'd0, out_acc}, 32'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
